// File: rtl/psg_bus_sequencer.sv
// Round-robin two-port arbiter that turns register requests into ym2149 BDIR/BC/DI
// phase sequences (latch, write/read, gap), skipping the latch when the address is cached.
module psg_bus_sequencer #(
   parameter bit ADDR_CACHE = 1'b1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       P0_REQ,
   input  logic       P0_WE,
   input  logic [3:0] P0_ADDR,
   input  logic [7:0] P0_WDATA,
   output logic       P0_ACK,
   output logic [7:0] P0_RDATA,
   input  logic       P1_REQ,
   input  logic [3:0] P1_ADDR,
   input  logic [7:0] P1_WDATA,
   output logic       P1_ACK,
   output logic       PSG_BDIR,
   output logic       PSG_BC,
   output logic [7:0] PSG_DI,
   input  logic [7:0] PSG_DO,
   output logic       BUSY
);

   typedef enum logic [2:0] {ST_IDLE, ST_LATCH, ST_WRITE, ST_READ, ST_GAP} state_t;

   state_t     state_q, state_d;
   logic       port_q, port_d;
   logic       we_q, we_d;
   logic [3:0] addr_q, addr_d;
   logic [7:0] wdata_q, wdata_d;
   logic       last_grant_q, last_grant_d;
   logic       cache_valid_q, cache_valid_d;
   logic [3:0] cache_addr_q, cache_addr_d;
   logic [7:0] rdata_q, rdata_d;
   logic       bdir_q, bdir_d;
   logic       bc_q, bc_d;
   logic [7:0] di_q, di_d;
   logic       p0_ack_q, p0_ack_d;
   logic       p1_ack_q, p1_ack_d;
   logic       grant1;

   always_comb begin
      state_d       = state_q;
      port_d        = port_q;
      we_d          = we_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      last_grant_d  = last_grant_q;
      cache_valid_d = cache_valid_q;
      cache_addr_d  = cache_addr_q;
      rdata_d       = rdata_q;
      // On a tie the port that did not win last time takes the bus.
      grant1        = P1_REQ && (!P0_REQ || !last_grant_q);

      case (state_q)
         ST_IDLE: begin
            if (P0_REQ || P1_REQ) begin
               port_d       = grant1;
               we_d         = grant1 ? 1'b1 : P0_WE;
               addr_d       = grant1 ? P1_ADDR : P0_ADDR;
               wdata_d      = grant1 ? P1_WDATA : P0_WDATA;
               last_grant_d = grant1;
               if (ADDR_CACHE && cache_valid_q && (addr_d == cache_addr_q))
                  state_d = we_d ? ST_WRITE : ST_READ;
               else
                  state_d = ST_LATCH;
            end
         end
         ST_LATCH: begin
            state_d       = we_q ? ST_WRITE : ST_READ;
            cache_addr_d  = addr_q;
            cache_valid_d = 1'b1;
         end
         ST_WRITE: state_d = ST_GAP;
         ST_READ: begin
            state_d = ST_GAP;
            rdata_d = PSG_DO;
         end
         ST_GAP:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Bus pins are decoded from the next state so they register in step with it.
      bdir_d = 1'b0;
      bc_d   = 1'b0;
      di_d   = 8'h00;
      case (state_d)
         ST_LATCH: begin
            bdir_d = 1'b1;
            bc_d   = 1'b1;
            di_d   = {4'h0, addr_d};
         end
         ST_WRITE: begin
            bdir_d = 1'b1;
            di_d   = wdata_d;
         end
         ST_READ: bc_d = 1'b1;
         default: ;
      endcase
      p0_ack_d = (state_d == ST_GAP) && !port_d;
      p1_ack_d = (state_d == ST_GAP) && port_d;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= ST_IDLE;
         last_grant_q  <= 1'b1;
         cache_valid_q <= 1'b0;
         rdata_q       <= 8'h00;
         bdir_q        <= 1'b0;
         bc_q          <= 1'b0;
         di_q          <= 8'h00;
         p0_ack_q      <= 1'b0;
         p1_ack_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         cache_valid_q <= cache_valid_d;
         rdata_q       <= rdata_d;
         bdir_q        <= bdir_d;
         bc_q          <= bc_d;
         di_q          <= di_d;
         p0_ack_q      <= p0_ack_d;
         p1_ack_q      <= p1_ack_d;
      end
   end

   // Transaction payload is only meaningful after a grant, so it carries no reset.
   always_ff @(posedge CLK) begin
      port_q       <= port_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cache_addr_q <= cache_addr_d;
   end

   assign P0_ACK   = p0_ack_q;
   assign P1_ACK   = p1_ack_q;
   assign P0_RDATA = rdata_q;
   assign PSG_BDIR = bdir_q;
   assign PSG_BC   = bc_q;
   assign PSG_DI   = di_q;
   assign BUSY     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_psg_bus_sequencer.sv
// Directed bench for psg_bus_sequencer with a small behavioural PSG register model.
module tb_psg_bus_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       p0_req, p0_we, p1_req;
   logic [3:0] p0_addr, p1_addr;
   logic [7:0] p0_wdata, p1_wdata;
   logic       nc_p0_req, nc_p1_req;

   logic       p0_ack, p1_ack, bdir, bc, busy;
   logic [7:0] p0_rdata, di;
   logic       n_p0_ack, n_p1_ack, n_bdir, n_bc, n_busy;
   logic [7:0] n_p0_rdata, n_di;
   logic [7:0] psg_do;

   int checks = 0;
   int failures = 0;
   bit use_nc = 1'b0;
   int cyc_n, n0, n1, nack;

   psg_bus_sequencer #(.ADDR_CACHE(1'b1)) dut (
      .CLK(clk), .RESET(rst),
      .P0_REQ(p0_req), .P0_WE(p0_we), .P0_ADDR(p0_addr), .P0_WDATA(p0_wdata),
      .P0_ACK(p0_ack), .P0_RDATA(p0_rdata),
      .P1_REQ(p1_req), .P1_ADDR(p1_addr), .P1_WDATA(p1_wdata), .P1_ACK(p1_ack),
      .PSG_BDIR(bdir), .PSG_BC(bc), .PSG_DI(di), .PSG_DO(psg_do), .BUSY(busy)
   );

   psg_bus_sequencer #(.ADDR_CACHE(1'b0)) dut_nc (
      .CLK(clk), .RESET(rst),
      .P0_REQ(nc_p0_req), .P0_WE(p0_we), .P0_ADDR(p0_addr), .P0_WDATA(p0_wdata),
      .P0_ACK(n_p0_ack), .P0_RDATA(n_p0_rdata),
      .P1_REQ(nc_p1_req), .P1_ADDR(p1_addr), .P1_WDATA(p1_wdata), .P1_ACK(n_p1_ack),
      .PSG_BDIR(n_bdir), .PSG_BC(n_bc), .PSG_DI(n_di), .PSG_DO(8'h00), .BUSY(n_busy)
   );

   // PSG model: latch address, write register, envelope restart one cycle after an R13 write edge.
   logic [7:0] psg_regs [16];
   logic [3:0] psg_active;
   logic       wr13_q, env_restart;
   int         cyc = 0;
   int         w13_cyc = -10;
   int         env_cyc = -100;

   assign psg_do = psg_regs[psg_active];

   always_ff @(posedge clk) begin
      cyc <= cyc + 1;
      if (bdir && bc) psg_active <= di[3:0];
      if (bdir && !bc) psg_regs[psg_active] <= di;
      wr13_q <= bdir && !bc && (psg_active == 4'd13);
      if (bdir && !bc && (psg_active == 4'd13)) w13_cyc <= cyc;
      env_restart <= wr13_q;
      if (wr13_q) env_cyc <= cyc;
   end

   logic [9:0] obs_bus;
   logic       obs_ack0, obs_ack1, obs_busy;
   logic [7:0] obs_rdata;
   assign obs_bus   = use_nc ? {n_bdir, n_bc, n_di} : {bdir, bc, di};
   assign obs_ack0  = use_nc ? n_p0_ack : p0_ack;
   assign obs_ack1  = use_nc ? n_p1_ack : p1_ack;
   assign obs_busy  = use_nc ? n_busy : busy;
   assign obs_rdata = use_nc ? n_p0_rdata : p0_rdata;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int port, input logic val);
      if (use_nc) begin
         if (port == 0) nc_p0_req = val; else nc_p1_req = val;
      end else begin
         if (port == 0) p0_req = val; else p1_req = val;
      end
   endtask

   // Called in the cycle the request is to be sampled; returns in the following IDLE cycle.
   task automatic xact(input int port, input logic we, input logic [3:0] a, input logic [7:0] d,
                       input logic hit, input logic [7:0] exp_rd);
      if (port == 0) begin
         p0_we = we; p0_addr = a; p0_wdata = d;
      end else begin
         p1_addr = a; p1_wdata = d;
      end
      set_req(port, 1'b1);
      step();
      if (!hit) begin
         check_val("latch_bus", obs_bus, {2'b11, 4'h0, a});
         check_val("latch_busy", obs_busy, 1);
         step();
      end
      check_val("data_bus", obs_bus, we ? {2'b10, d} : {2'b01, 8'h00});
      step();
      check_val("gap_bus", obs_bus, 0);
      check_val("gap_ack", {obs_ack1, obs_ack0}, (port == 0) ? 2'b01 : 2'b10);
      if (!we) check_val("rdata", obs_rdata, exp_rd);
      set_req(port, 1'b0);
      step();
      check_val("idle_ack", {obs_ack1, obs_ack0}, 0);
      check_val("idle_busy", obs_busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
      p1_req = 0; p1_addr = 0; p1_wdata = 0;
      nc_p0_req = 0; nc_p1_req = 0;
      step();
      step();
      check_val("rst_bus", {bdir, bc, di}, 0);
      check_val("rst_ack", {p1_ack, p0_ack}, 0);
      check_val("rst_rdata", p0_rdata, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_nc_bus", {n_bdir, n_bc, n_di, n_busy}, 0);
      rst = 1'b0;

      // Miss write, then hit write to the same register.
      xact(0, 1'b1, 4'd7, 8'h38, 1'b0, 8'h00);
      check_val("psg_active", psg_active, 7);
      check_val("psg_r7", psg_regs[7], 8'h38);
      xact(0, 1'b1, 4'd7, 8'h3F, 1'b1, 8'h00);
      check_val("psg_r7_hit", psg_regs[7], 8'h3F);

      // Write R0 then read it back on a cache hit; read data must hold.
      xact(0, 1'b1, 4'd0, 8'h5A, 1'b0, 8'h00);
      xact(0, 1'b0, 4'd0, 8'h00, 1'b1, 8'h5A);
      check_val("rdata_hold0", p0_rdata, 8'h5A);
      step();
      check_val("rdata_hold1", p0_rdata, 8'h5A);

      // Simultaneous requests after reset: strict alternation starting with port 0.
      rst = 1'b1;
      step();
      rst = 1'b0;
      p0_we = 1'b1; p0_addr = 4'd1; p0_wdata = 8'h10;
      p1_addr = 4'd2; p1_wdata = 8'h20;
      p0_req = 1'b1; p1_req = 1'b1;
      cyc_n = 0; n0 = 0; n1 = 0; nack = 0;
      while (nack < 6 && cyc_n < 40) begin
         step();
         cyc_n++;
         if (p0_ack || p1_ack) begin
            check_val("arb_ack_cycle", cyc_n, 3 + 4 * nack);
            check_val("arb_ack_port", {p1_ack, p0_ack}, (nack % 2 == 1) ? 2'b10 : 2'b01);
            if (p0_ack) begin
               check_val("arb_p0_reg", psg_regs[1], 8'(8'h10 + n0));
               n0++;
               p0_wdata = 8'(8'h10 + n0);
               if (n0 == 3) p0_req = 1'b0;
            end else begin
               check_val("arb_p1_reg", psg_regs[2], 8'(8'h20 + n1));
               n1++;
               p1_wdata = 8'(8'h20 + n1);
               if (n1 == 3) p1_req = 1'b0;
            end
            nack++;
            step();
            cyc_n++;
            check_val("arb_ack_pulse", {p1_ack, p0_ack}, 2'b00);
         end
      end
      check_val("arb_ack_count", nack, 6);
      p0_req = 1'b0; p1_req = 1'b0;

      // Reset during the WRITE phase of a port-1 write.
      p1_addr = 4'd5; p1_wdata = 8'h77; p1_req = 1'b1;
      step();
      check_val("abort_latch", {bdir, bc, di}, {2'b11, 8'h05});
      step();
      check_val("abort_write", {bdir, bc, di}, {2'b10, 8'h77});
      rst = 1'b1;
      step();
      check_val("abort_bus", {bdir, bc, di}, 0);
      check_val("abort_ack", {p1_ack, p0_ack}, 0);
      check_val("abort_busy", busy, 0);
      rst = 1'b0;
      xact(1, 1'b1, 4'd5, 8'h77, 1'b0, 8'h00);

      // Envelope register write followed by a cached read.
      xact(1, 1'b1, 4'd13, 8'h0E, 1'b0, 8'h00);
      check_val("env_restart", env_restart, 1);
      check_val("env_delay", env_cyc - w13_cyc, 1);
      xact(0, 1'b0, 4'd13, 8'h00, 1'b1, 8'h0E);

      // Cache disabled: repeated address still latches.
      use_nc = 1'b1;
      xact(0, 1'b1, 4'd7, 8'h38, 1'b0, 8'h00);
      xact(0, 1'b1, 4'd7, 8'h3F, 1'b0, 8'h00);
      use_nc = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/psg_bus_sequencer.md
# psg_bus_sequencer

Two-port arbiter and bus sequencer in front of the `ym2149` PSG. It accepts register read/write requests from the CPU I/O decoder (port 0) and write-only requests from the sound-init/config loader (port 1). It arbitrates between them round-robin and converts each granted request into the PSG's BDIR/BC/DI phase sequence: address latch, data write or read, then an idle gap. It skips the address-latch phase when the PSG already holds the requested register address.

## Interface

Parameters:
- ADDR_CACHE, 1: 1 enables skipping the LATCH phase on an address hit; 0 always latches.

Ports:
- CLK  in  1  system clock; same clock as `ym2149`.
- RESET  in  1  synchronous, active-high reset.
- P0_REQ  in  1  CPU request; held high until P0_ACK.
- P0_WE  in  1  1 = write, 0 = read.
- P0_ADDR  in  4  PSG register number.
- P0_WDATA  in  8  write data.
- P0_ACK  out  1  one-cycle completion pulse.
- P0_RDATA  out  8  read data; valid while P0_ACK=1 and held until the next port-0 read completes.
- P1_REQ  in  1  loader write request; held high until P1_ACK.
- P1_ADDR  in  4  PSG register number.
- P1_WDATA  in  8  write data.
- P1_ACK  out  1  one-cycle completion pulse.
- PSG_BDIR  out  1  to `ym2149` BDIR.
- PSG_BC  out  1  to `ym2149` BC.
- PSG_DI  out  8  to `ym2149` DI.
- PSG_DO  in  8  from `ym2149` DO (combinational on the PSG side).
- BUSY  out  1  high in any state other than IDLE.

## Operation

- States: IDLE, LATCH, WRITE, READ, GAP.
- Bus encoding per state, all registered outputs:
  - IDLE and GAP: BDIR=0, BC=0, DI=00.
  - LATCH: BDIR=1, BC=1, DI={4'h0, addr}.
  - WRITE: BDIR=1, BC=0, DI=wdata.
  - READ: BDIR=0, BC=1, DI=00.
- Arbitration happens in IDLE only:
  - If exactly one REQ is high, that port is granted.
  - If both are high, the port not granted last time wins.
  - `last_grant` resets to 1, so port 0 wins the first tie.
- On grant, the port number, we, addr and wdata are captured internally. Port 1 always has we=1. Later changes on the request inputs are ignored until ACK.
- Transition from IDLE on grant:
  - If ADDR_CACHE=1, `cache_valid`=1 and addr equals `cache_addr`, go directly to WRITE or READ.
  - Otherwise go to LATCH.
- LATCH -> WRITE or READ. On LATCH, set `cache_addr`=addr and `cache_valid`=1.
- WRITE -> GAP.
- READ -> GAP. PSG_DO is captured into P0_RDATA at the end of the READ cycle.
- GAP -> IDLE. The ACK of the granted port is high during GAP.
- No requests pending: remain in IDLE, bus inactive.
- A port dropping REQ before ACK is a protocol violation. The already-granted transaction still completes and ACKs.

## Timing

- Reset values, applied in the cycle after RESET is sampled:
  - state=IDLE.
  - PSG_BDIR=0, PSG_BC=0, PSG_DI=00.
  - P0_ACK=0, P1_ACK=0, P0_RDATA=00.
  - BUSY=0.
  - cache_valid=0, last_grant=1.
- RESET mid-transaction aborts it with no ACK. A requester still holding REQ is re-arbitrated from scratch after reset.
- Let T be the cycle in which REQ is sampled in IDLE. Miss timing:
  - T+1: LATCH.
  - T+2: WRITE or READ.
  - T+3: GAP with ACK.
  - T+4: IDLE, where the next arbitration occurs.
- Hit timing (LATCH skipped): data phase at T+1, ACK at T+2, next arbitration at T+3.
- Back-to-back throughput: one transaction per 4 cycles on a miss, per 3 cycles on a hit.
- The PSG register write takes effect at the clock edge ending the WRITE cycle. The PSG envelope restart (R13) follows that edge by one cycle.
- BDIR/BC never change from one active phase directly to a different address; GAP always separates transactions.

## Test plan

- After reset, P0 write R7=38: LATCH DI=07 at T+1, WRITE DI=38 at T+2, P0_ACK at T+3. PSG ACTIVE reads 07.
- P0 write R7=3F immediately after R7: no LATCH cycle, WRITE at T+1, ACK at T+2. Repeat with ADDR_CACHE=0: LATCH present.
- P0 read R0 after writing R0=5A: READ phase with BDIR=0, BC=1. P0_RDATA=5A with P0_ACK. P0_RDATA holds 5A afterwards.
- P0_REQ and P1_REQ raised in the same cycle, both held for three transactions each: grant order P0, P1, P0, P1, P0, P1. Each ACK is a single-cycle pulse.
- Assert RESET during the WRITE phase of a P1 write: no P1_ACK, bus inactive the next cycle. After reset the next access to the same register performs LATCH (cache invalidated).
- P1 writes R13=0E, then P0 reads R13: P0_RDATA=0E, and the PSG envelope restart is observed one cycle after the WRITE edge.
